// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: fetch/decode/redirect inputs and mux/forward/writeback outputs of the hazard controller
// Ports: fetch_addr, id_inst_raw, ex_redirect (master -> slave);
//        inst_sel, fa1/fb1, fa2/fb2, rf_we, rf_wa, instret (slave -> master)
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      fetch_addr;
    logic [31:0]      id_inst_raw;
    logic             ex_redirect;
    logic [1:0]       inst_sel;
    logic             fa1, fb1, fa2, fb2;
    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [CNT_W-1:0] instret;
    modport master (
        output fetch_addr, id_inst_raw, ex_redirect,
        input  inst_sel, fa1, fb1, fa2, fb2, rf_we, rf_wa, instret
    );
    modport slave (
        input  fetch_addr, id_inst_raw, ex_redirect,
        output inst_sel, fa1, fb1, fa2, fb2, rf_we, rf_wa, instret
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-source select, bubble insertion, forwarding selects and WB tracking for a 3-stage RV32 pipeline
// Ports: clk; rst_n (async, active-low); bus (slave): fetch_addr/id_inst_raw/ex_redirect in,
//        inst_sel (0 imem, 1 bios, 2 NOP), fa1/fb1 (ID), fa2/fb2 (EX), rf_we/rf_wa (WB), instret out
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    localparam logic [1:0] SEL_IMEM = 2'd0, SEL_BIOS = 2'd1, SEL_NOP = 2'd2;
    localparam logic [6:0] OP_LUI    = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL   = 7'b1101111,
                           OP_JALR   = 7'b1100111, OP_LOAD  = 7'b0000011, OP_IMM   = 7'b0010011,
                           OP_OP     = 7'b0110011, OP_BRANCH = 7'b1100011, OP_STORE = 7'b0100011;
    state_t           state;
    logic [1:0]       cnt, src_q, src_d, inst_sel;
    logic             ex_valid, ex_wen, ex_u1, ex_u2, wb_valid, wb_wen;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2, wb_rd, id_rd, id_rs1, id_rs2;
    logic [6:0]       opcode;
    logic [3:0]       nib;
    logic             redirect, id_valid, writes_rd, uses_rs1, uses_rs2, unused_ok;
    logic [CNT_W-1:0] instret_q;

    assign opcode    = bus.id_inst_raw[6:0];
    assign id_rd     = bus.id_inst_raw[11:7];
    assign id_rs1    = bus.id_inst_raw[19:15];
    assign id_rs2    = bus.id_inst_raw[24:20];
    assign nib       = bus.fetch_addr[31:28];
    assign unused_ok = ^{bus.fetch_addr[27:0], bus.id_inst_raw[31:25], bus.id_inst_raw[14:12]};

    // A redirect is only real when EX holds an instruction; during FLUSH EX holds a bubble.
    assign redirect  = (state == RUN) && bus.ex_redirect && ex_valid;
    assign inst_sel  = (state == RUN && !redirect) ? src_q : SEL_NOP;
    assign id_valid  = inst_sel != SEL_NOP;
    assign src_d     = (nib == 4'h4) ? SEL_BIOS : (nib == 4'h1 || nib == 4'h2) ? SEL_IMEM : SEL_NOP;

    // rd==0 clears the write enable, which is what keeps x0 out of every forwarding path.
    assign writes_rd = id_valid && (id_rd != 5'd0) &&
                       (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
    assign uses_rs1  = id_valid && (opcode inside {OP_JALR, OP_LOAD, OP_IMM, OP_OP, OP_BRANCH, OP_STORE});
    assign uses_rs2  = id_valid && (opcode inside {OP_BRANCH, OP_STORE, OP_OP});

    assign bus.inst_sel = inst_sel;
    assign bus.fa1      = wb_wen && uses_rs1 && (wb_rd == id_rs1);
    assign bus.fb1      = wb_wen && uses_rs2 && (wb_rd == id_rs2);
    assign bus.fa2      = wb_wen && ex_u1 && (wb_rd == ex_rs1);
    assign bus.fb2      = wb_wen && ex_u2 && (wb_rd == ex_rs2);
    assign bus.rf_we    = wb_wen;
    assign bus.rf_wa    = wb_rd;
    assign bus.instret  = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            cnt       <= '0;
            src_q     <= SEL_NOP;
            ex_valid  <= 1'b0;
            ex_wen    <= 1'b0;
            ex_u1     <= 1'b0;
            ex_u2     <= 1'b0;
            ex_rd     <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            wb_valid  <= 1'b0;
            wb_wen    <= 1'b0;
            wb_rd     <= '0;
            instret_q <= '0;
        end else begin
            state     <= (state == BOOT) ? RUN :
                         (state == RUN)  ? (redirect ? FLUSH : RUN) :
                         (cnt == 2'd1)   ? RUN : FLUSH;
            cnt       <= redirect ? 2'(FLUSH_CYCLES) : (state == FLUSH) ? cnt - 2'd1 : cnt;
            src_q     <= src_d;
            ex_valid  <= id_valid;
            ex_wen    <= writes_rd;
            ex_u1     <= uses_rs1;
            ex_u2     <= uses_rs2;
            ex_rd     <= id_valid ? id_rd : 5'd0;
            ex_rs1    <= id_valid ? id_rs1 : 5'd0;
            ex_rs2    <= id_valid ? id_rs2 : 5'd0;
            wb_valid  <= ex_valid;
            wb_wen    <= ex_wen;
            wb_rd     <= ex_rd;
            instret_q <= instret_q + CNT_W'(wb_valid);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of two pipe_hazard_ctrl configurations against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013, IMEM = 32'h1000_0000, BIOS = 32'h4000_0000,
                            BAD = 32'h8000_0000, JAL = 32'h0000_00EF;

    typedef struct packed {
        logic       v, w, u1, u2;
        logic [4:0] rd, rs1, rs2;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] fetch_addr = IMEM, id_inst_raw = NOP;
    logic        ex_redirect = 1'b0;
    int          passed = 0, total = 0;

    int          nop_left[2];
    logic [3:0]  nib[2];
    dec_t        ex_m[2], wb_m[2];
    logic [31:0] ret[2];

    pipe_hazard_ctrl_if #(.CNT_W(32)) b0 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  b1 ();

    assign b0.fetch_addr  = fetch_addr;
    assign b0.id_inst_raw = id_inst_raw;
    assign b0.ex_redirect = ex_redirect;
    assign b1.fetch_addr  = fetch_addr;
    assign b1.id_inst_raw = id_inst_raw;
    assign b1.ex_redirect = ex_redirect;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic dec_t dec(input logic [31:0] i, input logic v);
        dec_t d = '0;
        logic [6:0] op = i[6:0];
        if (v) begin
            d.v   = 1'b1;
            d.rd  = i[11:7];
            d.rs1 = i[19:15];
            d.rs2 = i[24:20];
            d.w   = (i[11:7] != 5'd0) && (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33});
            d.u1  = op inside {7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23};
            d.u2  = op inside {7'h63, 7'h23, 7'h33};
        end
        return d;
    endfunction

    // Model: nop_left counts remaining forced-NOP cycles (boot or post-redirect).
    function automatic logic [1:0] msel(input int k);
        if (nop_left[k] > 0 || (ex_redirect && ex_m[k].v)) return 2'd2;
        if (nib[k] == 4'h4) return 2'd1;
        if (nib[k] == 4'h1 || nib[k] == 4'h2) return 2'd0;
        return 2'd2;
    endfunction

    function automatic logic [11:0] mexp(input int k);
        logic [1:0] s = msel(k);
        dec_t d = dec(id_inst_raw, s != 2'd2);
        dec_t w = wb_m[k];
        dec_t e = ex_m[k];
        return {s, w.w && d.u1 && w.rd == d.rs1, w.w && d.u2 && w.rd == d.rs2,
                w.w && e.u1 && w.rd == e.rs1, w.w && e.u2 && w.rd == e.rs2, w.w, w.rd};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                nop_left[k] <= 1;
                nib[k]      <= 4'h0;
                ex_m[k]     <= '0;
                wb_m[k]     <= '0;
                ret[k]      <= '0;
            end else begin
                nop_left[k] <= (nop_left[k] > 0) ? nop_left[k] - 1 :
                               (ex_redirect && ex_m[k].v) ? (k == 0 ? 1 : 3) : 0;
                nib[k]      <= fetch_addr[31:28];
                ex_m[k]     <= dec(id_inst_raw, msel(k) != 2'd2);
                wb_m[k]     <= ex_m[k];
                ret[k]      <= ret[k] + 32'(wb_m[k].v);
            end
        end
    end

    always @(negedge clk) begin
        chk("outs0", {20'b0, b0.inst_sel, b0.fa1, b0.fb1, b0.fa2, b0.fb2, b0.rf_we, b0.rf_wa}, {20'b0, mexp(0)});
        chk("outs1", {20'b0, b1.inst_sel, b1.fa1, b1.fb1, b1.fa2, b1.fb2, b1.rf_we, b1.rf_wa}, {20'b0, mexp(1)});
        chk("instret0", b0.instret, ret[0]);
        chk("instret1", 32'(b1.instret), ret[1] & 32'hF);
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] i, input logic r, input logic rn);
        @(posedge clk);
        #1;
        fetch_addr  = a;
        id_inst_raw = i;
        ex_redirect = r;
        rst_n       = rn;
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23, 7'h7F};
        logic [3:0]  nibs[7] = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h8, 4'hF, 4'h3};
        logic [31:0] r, a;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cyc(IMEM, NOP, 0, 1);
        chk("boot_sel", 32'(b0.inst_sel), 2);
        cyc(IMEM, NOP, 0, 1);
        chk("imem_sel", 32'(b0.inst_sel), 0);
        cyc(IMEM, addi(1, 0, 5), 0, 1);
        cyc(IMEM, addi(2, 1, 1), 0, 1);
        cyc(IMEM, NOP, 0, 1);
        chk("fwd_fa2", 32'(b0.fa2), 1);
        chk("fwd_fb2", 32'(b0.fb2), 0);
        cyc(IMEM, addi(0, 0, 5), 0, 1);
        cyc(IMEM, addi(2, 0, 1), 0, 1);
        cyc(IMEM, NOP, 0, 1);
        chk("x0_fa2", 32'(b0.fa2), 0);
        cyc(IMEM, addi(3, 0, 7), 0, 1);
        cyc(IMEM, NOP, 0, 1);
        cyc(IMEM, add(4, 3, 3), 0, 1);
        chk("id_fa1", 32'(b0.fa1), 1);
        chk("id_fb1", 32'(b0.fb1), 1);
        chk("id_rf_wa", 32'(b0.rf_wa), 3);
        chk("id_rf_we", 32'(b0.rf_we), 1);
        cyc(IMEM, JAL, 0, 1);
        cyc(IMEM, NOP, 1, 1);
        chk("redir_T", 32'(b0.inst_sel), 2);
        chk("redir_T_fc3", 32'(b1.inst_sel), 2);
        cyc(IMEM, NOP, 1, 1);
        chk("redir_T1", 32'(b0.inst_sel), 2);
        cyc(IMEM, NOP, 0, 1);
        chk("redir_T2", 32'(b0.inst_sel), 0);
        chk("redir_T2_fc3", 32'(b1.inst_sel), 2);
        cyc(IMEM, NOP, 0, 1);
        chk("redir_T3_fc3", 32'(b1.inst_sel), 2);
        cyc(BAD, NOP, 0, 1);
        chk("redir_T4_fc3", 32'(b1.inst_sel), 0);
        cyc(IMEM, NOP, 0, 1);
        chk("bad_sel", 32'(b0.inst_sel), 2);
        cyc(IMEM, addi(5, 0, 1), 0, 1);
        cyc(IMEM, NOP, 0, 1);
        cyc(BIOS, NOP, 0, 1);
        chk("pre_rst_we", 32'(b0.rf_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", 32'(b0.inst_sel), 2);
        chk("rst_we", 32'(b0.rf_we), 0);
        chk("rst_instret", b0.instret, 0);
        cyc(BIOS, NOP, 0, 0);
        cyc(BIOS, NOP, 0, 1);
        chk("rel_boot_sel", 32'(b0.inst_sel), 2);
        cyc(BIOS, NOP, 0, 1);
        chk("rel_bios_sel", 32'(b0.inst_sel), 1);
        cyc(IMEM, NOP, 0, 0);
        cyc(IMEM, addi(5, 5, 1), 0, 1);
        for (int c = 1; c <= 23; c++) begin
            cyc(((c >= 10 && c <= 12) || c >= 20) ? BAD : IMEM, addi(5, 5, 1), 0, 1);
            if (c == 13) begin
                chk("instret_10", b0.instret, 10);
                chk("instret_10_w4", 32'(b1.instret), 10);
            end
            if (c == 23) begin
                chk("instret_17", b0.instret, 17);
                chk("instret_17_w4", 32'(b1.instret), 1);
            end
        end
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            a = {nibs[$urandom_range(0, 6)], 28'($urandom)};
            cyc(a, {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
                    5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]},
                $urandom_range(0, 4) == 0, $urandom_range(0, 149) != 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
